// File: rtl/mod_updown_counter.sv
// General-purpose up/down counter with programmable modulus, clock prescaler,
// synchronous clear/load and wrap-or-saturate behaviour at the count limits.
module mod_updown_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VALUE = 2**WIDTH - 1,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Up,
   input  logic             Saturate,
   input  logic             Clear,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadValue,
   output logic [WIDTH-1:0] Output,
   output logic             Wrap,
   output logic             AtLimit
);

   // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] ZERO_V  = '0;
   localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);

   logic [PS_W-1:0]  ps_cnt;
   logic [PS_W-1:0]  ps_next;
   logic             step;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_next;
   logic             wrap_next;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (Output == MAX_V);
   assign at_zero = (Output == ZERO_V);
   assign AtLimit = Up ? at_max : at_zero;

   assign step         = Enable && (ps_cnt == PS_LAST);
   assign load_clamped = (LoadValue > MAX_V) ? MAX_V : LoadValue;

   always_comb begin
      ps_next = ps_cnt;
      if (Enable) begin
         ps_next = (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_ONE;
      end
   end

   // Step result; the wrap flag is only ever raised on a non-saturating limit step.
   always_comb begin
      count_next = Output;
      wrap_next  = 1'b0;
      if (step) begin
         if (Up) begin
            if (!at_max) begin
               count_next = Output + ONE_V;
            end else if (!Saturate) begin
               count_next = ZERO_V;
               wrap_next  = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               count_next = Output - ONE_V;
            end else if (!Saturate) begin
               count_next = MAX_V;
               wrap_next  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         Output <= '0;
         Wrap   <= 1'b0;
         ps_cnt <= '0;
      end else if (Clear) begin
         Output <= '0;
         Wrap   <= 1'b0;
         ps_cnt <= '0;
      end else if (Load) begin
         Output <= load_clamped;
         Wrap   <= 1'b0;
         ps_cnt <= '0;
      end else begin
         Output <= count_next;
         Wrap   <= wrap_next;
         ps_cnt <= ps_next;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed test of mod_updown_counter: modulus-10 counter, with and without a
// divide-by-3 prescaler, sharing one set of stimulus inputs.
module tb_mod_updown_counter;

   logic       Clock;
   logic       Reset;
   logic       Enable;
   logic       Up;
   logic       Saturate;
   logic       Clear;
   logic       Load;
   logic [3:0] LoadValue;
   logic [3:0] out_a;
   logic       wrap_a;
   logic       lim_a;
   logic [3:0] out_b;
   logic       wrap_b;
   logic       lim_b;

   int n_assert = 0;
   int n_fail   = 0;

   mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1)) dut_a (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Saturate(Saturate),
      .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
      .Output(out_a), .Wrap(wrap_a), .AtLimit(lim_a)
   );

   mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3)) dut_b (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Saturate(Saturate),
      .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
      .Output(out_b), .Wrap(wrap_b), .AtLimit(lim_b)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   logic [3:0] exp_up   [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
   logic [3:0] exp_ps   [11] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
   logic       en_ps    [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      Reset = 1'b0; Enable = 1'b0; Up = 1'b1; Saturate = 1'b0;
      Clear = 1'b0; Load = 1'b0; LoadValue = 4'd0;
      #2;
      check("reset_out_a", 8'(out_a), 8'd0);
      check("reset_wrap_a", 8'(wrap_a), 8'd0);
      check("reset_out_b", 8'(out_b), 8'd0);
      tick();
      tick();
      Reset = 1'b1;

      // Modulus-10 up count with wrap
      Enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("up_out_%0d", i), 8'(out_a), 8'(exp_up[i]));
         check($sformatf("up_wrap_%0d", i), 8'(wrap_a), 8'(exp_up[i] == 4'd0));
      end

      // Down count from 0 wraps to 9
      Clear = 1'b1;
      tick();
      check("clear_out", 8'(out_a), 8'd0);
      check("clear_wrap", 8'(wrap_a), 8'd0);
      Clear = 1'b0;
      Up = 1'b0;
      #1;
      check("atlimit_down_zero", 8'(lim_a), 8'd1);
      tick();
      check("down_out_9", 8'(out_a), 8'd9);
      check("down_wrap_9", 8'(wrap_a), 8'd1);
      check("down_atlimit_9", 8'(lim_a), 8'd0);
      tick();
      check("down_out_8", 8'(out_a), 8'd8);
      check("down_wrap_8", 8'(wrap_a), 8'd0);
      tick();
      check("down_out_7", 8'(out_a), 8'd7);

      // Saturating up count from a load of 8
      Saturate = 1'b1; Up = 1'b1; Load = 1'b1; LoadValue = 4'd8;
      tick();
      check("sat_load_8", 8'(out_a), 8'd8);
      check("sat_atlimit_8", 8'(lim_a), 8'd0);
      Load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("sat_out_%0d", i), 8'(out_a), 8'd9);
         check($sformatf("sat_wrap_%0d", i), 8'(wrap_a), 8'd0);
         check($sformatf("sat_atlimit_%0d", i), 8'(lim_a), 8'd1);
      end

      // Load clamps to MAX_VALUE; Clear beats Load
      Load = 1'b1; LoadValue = 4'd15;
      tick();
      check("load_clamp", 8'(out_a), 8'd9);
      Clear = 1'b1;
      tick();
      check("clear_over_load", 8'(out_a), 8'd0);
      Clear = 1'b0; Load = 1'b0;

      // Saturating down at 0 holds without wrap
      Up = 1'b0;
      tick();
      check("sat_down_hold", 8'(out_a), 8'd0);
      check("sat_down_wrap", 8'(wrap_a), 8'd0);

      // Enable low holds the count
      Up = 1'b1; Saturate = 1'b0; Load = 1'b1; LoadValue = 4'd4;
      tick();
      Load = 1'b0; Enable = 1'b0;
      tick();
      tick();
      check("enable_hold", 8'(out_a), 8'd4);

      // Prescale-by-3 with a 2-cycle Enable gap mid-interval
      Clear = 1'b1;
      tick();
      check("ps_clear_b", 8'(out_b), 8'd0);
      Clear = 1'b0;
      for (int i = 0; i < 11; i++) begin
         Enable = en_ps[i];
         tick();
         check($sformatf("ps_out_%0d", i), 8'(out_b), 8'(exp_ps[i]));
      end

      // Async reset mid-cycle while the count is 6
      Enable = 1'b1; Clear = 1'b1;
      tick();
      Clear = 1'b0;
      repeat (6) tick();
      check("pre_reset_out", 8'(out_a), 8'd6);
      #3;
      Reset = 1'b0;
      #1;
      check("async_reset_out_a", 8'(out_a), 8'd0);
      check("async_reset_wrap_a", 8'(wrap_a), 8'd0);
      check("async_reset_out_b", 8'(out_b), 8'd0);
      #2;
      Reset = 1'b1;
      tick();
      check("resume_a_1", 8'(out_a), 8'd1);
      check("resume_b_0a", 8'(out_b), 8'd0);
      tick();
      check("resume_b_0b", 8'(out_b), 8'd0);
      tick();
      check("resume_b_1", 8'(out_b), 8'd1);
      check("resume_a_3", 8'(out_a), 8'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
